// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes, state encoding and vector types for the round-robin mux arbiter
package mux_arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, GRANT} arb_state_e;
  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux_rr_pick.sv
// mux_rr_pick: rotating priority pick, searching start_i+1, start_i+2, ... and start_i itself last
//  req_i    in  requests to choose from
//  start_i  in  index of lowest-priority requester
//  found_o  out any request set
//  idx_o    out chosen index
//  onehot_o out chosen index as one-hot, 0 when nothing found
module mux_rr_pick
  import mux_arb_pkg::*;
(
  input  req_vec_t req_i,
  input  sel_t     start_i,
  output logic     found_o,
  output sel_t     idx_o,
  output req_vec_t onehot_o
);
  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o = start_i;
    for (int k = N_REQ; k >= 1; k--)
      if (req_i[sel_t'(start_i + sel_t'(k))]) begin
        found_o = 1'b1;
        idx_o = sel_t'(start_i + sel_t'(k));
      end
    onehot_o = found_o ? req_vec_t'(1) << idx_o : '0;
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter driving a 4:1 bit mux with a valid/ready output register
//  clk, rst            clock, synchronous active-high reset
//  req_i, data_i       request levels and mux data inputs per requester
//  gnt_o, sel_o        one-hot grant and mux select
//  acc_o               pulse: granted requester's beat captured this cycle
//  out_valid_o/out_ready_i/out_data_o/out_src_o  output beat handshake
//  lock_i              present only with MUX_ARB_LOCK_EN; suppresses HOLD_MAX rotation for the granted requester
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  req_vec_t req_i,
  input  req_vec_t data_i,
`ifdef MUX_ARB_LOCK_EN
  input  req_vec_t lock_i,
`endif
  output req_vec_t gnt_o,
  output sel_t     sel_o,
  output req_vec_t acc_o,
  output logic     out_valid_o,
  input  logic     out_ready_i,
  output logic     out_data_o,
  output sel_t     out_src_o
);
  localparam int CW = $clog2(HOLD_MAX + 1);
  typedef logic [CW-1:0] cnt_t;
  arb_state_e state_q;
  req_vec_t   gnt_q;
  sel_t       sel_q, ptr_q, src_q;
  cnt_t       cnt_q;
  logic       valid_q, data_q;
  logic       granted, cap, lock_g, last, end_g, found;
  sel_t       pick_idx;
  req_vec_t   pick_oh;
  always_comb begin
    granted = state_q == GRANT;
    cap = granted && req_i[sel_q] && (!valid_q || out_ready_i);
`ifdef MUX_ARB_LOCK_EN
    lock_g = lock_i[sel_q];
`else
    lock_g = 1'b0;
`endif
    last = cnt_q == cnt_t'(HOLD_MAX - 1);
    end_g = granted && (!req_i[sel_q] || (cap && last && !lock_g));
  end
  // The granted index is the lowest-priority slot at end of grant; from IDLE the pointer is.
  mux_rr_pick u_pick (
    .req_i    (req_i),
    .start_i  (granted ? sel_q : ptr_q),
    .found_o  (found),
    .idx_o    (pick_idx),
    .onehot_o (pick_oh)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      sel_q <= '0;
      ptr_q <= sel_t'(N_REQ - 1);
      cnt_q <= '0;
      valid_q <= 1'b0;
      data_q <= 1'b0;
      src_q <= '0;
    end else begin
      if (cap) begin
        valid_q <= 1'b1;
        data_q <= data_i[sel_q];
        src_q <= sel_q;
      end else if (out_ready_i) valid_q <= 1'b0;
      if (!granted) begin
        if (found) begin
          state_q <= GRANT;
          gnt_q <= pick_oh;
          sel_q <= pick_idx;
          cnt_q <= '0;
        end
      end else if (end_g) begin
        ptr_q <= sel_q;
        cnt_q <= '0;
        gnt_q <= pick_oh;
        sel_q <= found ? pick_idx : sel_q;
        state_q <= found ? GRANT : IDLE;
      end else if (cap && !(lock_g && last)) cnt_q <= cnt_q + cnt_t'(1);
    end
  end
  assign gnt_o = gnt_q;
  assign sel_o = sel_q;
  assign acc_o = cap ? gnt_q : '0;
  assign out_valid_o = valid_q;
  assign out_data_o = data_q;
  assign out_src_o = src_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed and random stimulus checked against a behavioural arbiter model
module tb_mux_rr_arbiter;
  localparam int HOLD = 4;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic [3:0] req = 4'hF, data = '0, lock = '0;
  logic [3:0] gnt_o, acc_o;
  logic [1:0] sel_o, src_o;
  logic valid_o, data_o;
  int n_assert = 0, n_fail = 0;
  int mg = -1, msel = 0, mptr = 3, mbeats = 0, ms = 0;
  bit mv = 0, md = 0;
  always #5 clk = ~clk;
  mux_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .req_i(req), .data_i(data),
`ifdef MUX_ARB_LOCK_EN
    .lock_i(lock),
`endif
    .gnt_o(gnt_o), .sel_o(sel_o), .acc_o(acc_o), .out_valid_o(valid_o),
    .out_ready_i(rdy), .out_data_o(data_o), .out_src_o(src_o)
  );
  function automatic int pick(int s, logic [3:0] r);
    for (int o = 1; o <= 4; o++) if (r[(s + o) % 4]) return (s + o) % 4;
    return -1;
  endfunction
  function automatic logic [3:0] oh(int i);
    return i < 0 ? 4'b0 : 4'(1 << i);
  endfunction
  function automatic bit m_cap();
    return mg >= 0 && req[mg] && (!mv || rdy);
  endfunction
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic m_step();
    bit cap, lk;
    int p;
    if (rst) begin
      mg = -1; msel = 0; mptr = 3; mbeats = 0; mv = 0; md = 0; ms = 0;
      return;
    end
    cap = m_cap();
`ifdef MUX_ARB_LOCK_EN
    lk = mg >= 0 && lock[mg];
`else
    lk = 0;
`endif
    if (cap) begin mv = 1; md = data[mg]; ms = mg; end
    else if (rdy) mv = 0;
    if (mg < 0) begin
      p = pick(mptr, req);
      if (p >= 0) begin mg = p; msel = p; mbeats = 0; end
    end else if (!req[mg] || (cap && mbeats + 1 >= HOLD && !lk)) begin
      mptr = mg; mbeats = 0;
      p = pick(mg, req);
      mg = p;
      if (p >= 0) msel = p;
    end else if (cap) mbeats++;
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("gnt", 8'(gnt_o), 8'(oh(mg)));
    chk("sel", 8'(sel_o), 8'(msel));
    chk("acc", 8'(acc_o), 8'(m_cap() ? oh(mg) : 4'b0));
    chk("valid", 8'(valid_o), 8'(mv));
    chk("data", 8'(data_o), 8'(md));
    chk("src", 8'(src_o), 8'(ms));
    @(posedge clk);
    m_step();
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    cyc();
    chk("rst_gnt", 8'(gnt_o), 8'h00);
    chk("rst_valid", 8'(valid_o), 8'h00);
    rst = 1'b0;
    cyc();
    chk("first_gnt", 8'(gnt_o), 8'h01);
    chk("first_sel", 8'(sel_o), 8'h00);
    req = 4'b0100; data = 4'b0100;
    cyc(); cyc();
    for (int i = 0; i < 10; i++) begin
      chk("solo_gnt", 8'(gnt_o), 8'h04);
      chk("solo_acc", 8'(acc_o), 8'h04);
      chk("solo_data", 8'(data_o), 8'h01);
      chk("solo_src", 8'(src_o), 8'h02);
      cyc();
    end
    req = 4'hF;
    for (int i = 0; i < 20; i++) begin data = 4'($urandom); cyc(); end
    for (int i = 0; i < 6; i++) begin rdy = i >= 2 && i < 5 ? 1'b0 : 1'b1; data = 4'($urandom); cyc(); end
    rdy = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 4'b0011;
    cyc(); cyc(); cyc();
    req = 4'b0010; cyc();
    chk("drop_gnt", 8'(gnt_o), 8'h02);
    req = 4'b0000; cyc();
    chk("idle_gnt", 8'(gnt_o), 8'h00);
    cyc();
`ifdef MUX_ARB_LOCK_EN
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 4'hF; lock = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i >= 1) chk("lock_hold", 8'(gnt_o), 8'h01);
    end
    lock = '0;
    for (int i = 0; i < 4; i++) cyc();
`endif
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(99) == 0;
      req = $urandom_range(3) == 0 ? 4'($urandom) : req ^ 4'(1 << $urandom_range(3));
      data = 4'($urandom);
      rdy = $urandom_range(9) < 7;
`ifdef MUX_ARB_LOCK_EN
      lock = $urandom_range(4) == 0 ? 4'($urandom) : lock;
`endif
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
